decod3to8seq: RTL

Timed 3-to-8 line decoder: the decode-side counterpart of the team's 8-to-3 priority encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles, then drives a blanking gap. It sits at the decode end of the encoder/decoder pair, turning a packed select code back into a strobed one-hot select bus.

---
 rtl/decod3to8seq_pkg.sv | 30 +++
 rtl/decod3to8bl.sv | 11 +
 rtl/decod3to8seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/decod3to8seq_pkg.sv
// Shared types, parameter limits and helpers for the timed 3-to-8 decoder.
// State encoding is fixed so external debug tooling can read the state register.
package decod_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int HOLD_MIN = 1;
   localparam int HOLD_MAX = 255;
   localparam int GAP_MIN  = 0;
   localparam int GAP_MAX  = 255;

   function automatic logic [7:0] onehot3to8(input logic [2:0] code);
      return 8'(1) << code;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/decod3to8bl.sv
// Purely combinational 3-to-8 line decoder: binary code in, one-hot line out.
module decod3to8bl
   import decod_pkg::*;
(
   input  logic [2:0] a,
   output logic [7:0] y
);

   assign y = onehot3to8(a);

endmodule

// File: rtl/decod3to8seq.sv
// Timed 3-to-8 decoder: accepts a code over valid/ready, drives its one-hot line
// for HOLD cycles, then blanks for GAP cycles before returning to IDLE.
module decod3to8seq
   import decod_pkg::*;
#(
   parameter int HOLD = 4,
   parameter int GAP  = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] A,
   input  logic       en,
   input  logic       clr,
   output logic [7:0] Y,
   output logic [2:0] code_q,
   output logic       busy,
   output logic       done
);

   // Out-of-range parameters are pulled into the legal window rather than wrapping.
   localparam int HOLD_C  = clamp(HOLD, HOLD_MIN, HOLD_MAX);
   localparam int GAP_C   = clamp(GAP, GAP_MIN, GAP_MAX);
   localparam int CNT_MAX = max3(HOLD_C, GAP_C, 2);
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_C - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_C > 0) ? GAP_C - 1 : 0);

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [7:0]    y_reg;
   logic [2:0]    code_reg;
   logic          done_reg;

   logic [2:0]    dec_sel;
   logic [7:0]    dec_y;
   logic [7:0]    y_next;

   // In IDLE the decoder looks at the incoming code so the accept edge already drives Y.
   assign dec_sel = (state_reg == IDLE) ? A : code_reg;

   decod3to8bl u_dec (
      .a (dec_sel),
      .y (dec_y)
   );

   assign y_next = en ? dec_y : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         y_reg     <= 8'h00;
         code_reg  <= 3'd0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               y_reg <= 8'h00;
               if (in_valid && !clr) begin
                  code_reg  <= A;
                  y_reg     <= y_next;
                  cnt_reg   <= HOLD_LOAD;
                  state_reg <= DRIVE;
               end
            end
            DRIVE: begin
               if (clr) begin
                  y_reg     <= 8'h00;
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CW'(1);
                  y_reg   <= y_next;
               end else begin
                  y_reg <= 8'h00;
                  if (GAP_C > 0) begin
                     cnt_reg   <= GAP_LOAD;
                     state_reg <= decod_pkg::GAP;
                  end else begin
                     state_reg <= IDLE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            decod_pkg::GAP: begin
               y_reg <= 8'h00;
               if (clr) begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - CW'(1);
               end else begin
                  state_reg <= IDLE;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               y_reg     <= 8'h00;
               cnt_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_reg == IDLE) && !rst;
   assign busy     = (state_reg == DRIVE) || (state_reg == decod_pkg::GAP);
   assign Y        = y_reg;
   assign code_q   = code_reg;
   assign done     = done_reg;

endmodule
